alu_seq: RTL

- Parametrised, registered successor to the team's 4-bit combinational ALU.
- Adds the following to the existing operand/opcode/flag datapath:
  - WIDTH generalisation
  - valid/ready handshakes on input and output
  - signed overflow and negative flags
  - shift operations
  - an iterative shift-add multiplier with a high result word
- Sits between an operand-issue stage and a result-consumer stage that may apply backpressure.

---
 rtl/alu_seq.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes on both sides, signed/unsigned
// flags, shifts and an iterative shift-add multiplier producing a double-width product.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       opcode,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] results,
  output logic [WIDTH-1:0] results_hi,
  output logic             zero_flag,
  output logic             carry_flag,
  output logic             overflow_flag,
  output logic             negative_flag,
  output logic             illegal_op,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW:0] CNT_LAST = (SHW+1)'(WIDTH);
  localparam logic [3:0] OP_MUL = 4'd11;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t r_state, w_state_nxt;
  logic w_in_ready, w_out_valid, w_accept, w_is_mul, w_mul_last;

  logic [SHW:0]         r_cnt;
  logic [WIDTH-1:0]     r_mcand;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH:0]       w_psum;
  logic [2*WIDTH-1:0]   w_acc_step;

  logic [WIDTH-1:0]     r_res, r_res_hi;
  logic                 r_zero, r_carry, r_ovf, r_neg, r_illegal;

  logic [WIDTH-1:0]     w_res;
  logic                 w_carry, w_ovf, w_illegal;
  logic [WIDTH:0]       w_add, w_sub;
  logic [SHW-1:0]       w_sh;
  logic [2*WIDTH-1:0]   w_shl, w_shr;
  logic signed [2*WIDTH-1:0] w_sra;

  assign w_is_mul   = (opcode == OP_MUL);
  assign w_accept   = in_valid && w_in_ready;
  assign w_mul_last = (r_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (in_valid) w_state_nxt = w_is_mul ? BUSY : DONE;
      end
      BUSY: begin
        if (w_mul_last) w_state_nxt = DONE;
      end
      DONE: begin
        w_out_valid = 1'b1;
        w_in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) w_state_nxt = w_is_mul ? BUSY : DONE;
          else          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Single-cycle operations; shifts are done in a double-width window so the
  // bit adjacent to the kept half is the last bit shifted out (0 for amount 0).
  assign w_sh  = B[SHW-1:0];
  assign w_add = {1'b0, A} + {1'b0, B};
  assign w_sub = {1'b0, A} - {1'b0, B};
  assign w_shl = {{WIDTH{1'b0}}, A} << w_sh;
  assign w_shr = {A, {WIDTH{1'b0}}} >> w_sh;
  assign w_sra = $signed({A, {WIDTH{1'b0}}}) >>> w_sh;

  always_comb begin
    w_res     = '0;
    w_carry   = 1'b0;
    w_ovf     = 1'b0;
    w_illegal = 1'b0;
    case (opcode)
      4'd0: begin
        {w_carry, w_res} = w_add;
        w_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (w_add[WIDTH-1] != A[WIDTH-1]);
      end
      4'd1: begin
        {w_carry, w_res} = w_sub;
        w_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (w_sub[WIDTH-1] != A[WIDTH-1]);
      end
      4'd2: w_res = A & B;
      4'd3: w_res = A | B;
      4'd4: w_res = A ^ B;
      4'd5: w_res = ~A;
      4'd6: w_res = {{(WIDTH-1){1'b0}}, (A > B)};
      4'd7: w_res = {{(WIDTH-1){1'b0}}, ($signed(A) > $signed(B))};
      4'd8: begin
        w_res   = w_shl[WIDTH-1:0];
        w_carry = w_shl[WIDTH];
      end
      4'd9: begin
        w_res   = w_shr[2*WIDTH-1:WIDTH];
        w_carry = w_shr[WIDTH-1];
      end
      4'd10: begin
        w_res   = w_sra[2*WIDTH-1:WIDTH];
        w_carry = w_sra[WIDTH-1];
      end
      4'd11: w_res = '0;
      default: w_illegal = 1'b1;
    endcase
  end

  // Multiplier: low half of the accumulator holds the remaining multiplier bits.
  assign w_psum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
  assign w_acc_step = {w_psum, r_acc[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (w_accept && w_is_mul) begin
      r_mcand <= A;
      r_acc   <= {{WIDTH{1'b0}}, B};
    end else if (r_state == BUSY) begin
      r_acc <= w_acc_step;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        r_cnt <= '0;
    else if (w_accept && w_is_mul)  r_cnt <= '0;
    else if (r_state == BUSY)       r_cnt <= r_cnt + 1'b1;
  end

  // Output stage: results and flags launch together with out_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res     <= '0;
      r_res_hi  <= '0;
      r_zero    <= 1'b0;
      r_carry   <= 1'b0;
      r_ovf     <= 1'b0;
      r_neg     <= 1'b0;
      r_illegal <= 1'b0;
    end else if (w_accept && !w_is_mul) begin
      r_res     <= w_res;
      r_res_hi  <= '0;
      r_zero    <= (w_res == '0);
      r_carry   <= w_carry;
      r_ovf     <= w_ovf;
      r_neg     <= w_res[WIDTH-1];
      r_illegal <= w_illegal;
    end else if (r_state == BUSY && w_mul_last) begin
      r_res     <= r_acc[WIDTH-1:0];
      r_res_hi  <= r_acc[2*WIDTH-1:WIDTH];
      r_zero    <= (r_acc == '0);
      r_carry   <= |r_acc[2*WIDTH-1:WIDTH];
      r_ovf     <= 1'b0;
      r_neg     <= r_acc[WIDTH-1];
      r_illegal <= 1'b0;
    end
  end

  assign in_ready      = w_in_ready;
  assign out_valid     = w_out_valid;
  assign results       = r_res;
  assign results_hi    = r_res_hi;
  assign zero_flag     = r_zero;
  assign carry_flag    = r_carry;
  assign overflow_flag = r_ovf;
  assign negative_flag = r_neg;
  assign illegal_op    = r_illegal;

endmodule
